// File: rtl/reg_file_pkg.sv
// Shared definitions for the 2-read/1-write register file.
// Holds the default geometry and the operation encoding used to decide
// whether a cycle writes, exchanges, or leaves the bank alone.
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 8;

    // What the bank does at the coming falling edge
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_XCHG  = 2'd2
    } op_t;

    // Exchange wins over write; a write that loses is simply dropped
    function automatic op_t select_op(input logic wr_en, input logic xchg_en);
        op_t op;
        op = OP_IDLE;
        if (xchg_en) begin
            op = OP_XCHG;
        end else if (wr_en) begin
            op = OP_WRITE;
        end
        return op;
    endfunction

endpackage

// File: rtl/reg_file_cell.sv
// One storage word of the register file: a DATA_W-bit register with an
// asynchronous active-low clear and a load enable, updated on the falling
// clock edge like the rest of the datapath.
module reg_file_cell
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_en,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] q
);

    // Load the new word when enabled, otherwise keep the stored value
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (ld_en) begin
            q <= ld_data;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with two registered read ports, one write port, an atomic
// exchange of the two read-addressed registers and a registered write ack.
// All state changes on the falling edge of clk; clr is an async active-low
// clear of the whole bank and of the output registers.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-edge write
// data to a read port whose address matches wr_addr.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_valid,
    input  logic              xchg_en
);

    op_t               op;
    logic [DEPTH-1:0]  ld_en;
    logic [DATA_W-1:0] ld_data [DEPTH];
    logic [DATA_W-1:0] q       [DEPTH];
    logic [DATA_W-1:0] rd_a_next;
    logic [DATA_W-1:0] rd_b_next;

    // Decide the operation for this edge (exchange beats write)
    always_comb begin
        op = select_op(wr_en, xchg_en);
    end

    // Per-register load enables and load data for write and exchange
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ld_en[i]   = 1'b0;
            ld_data[i] = q[i];
            case (op)
                OP_WRITE: begin
                    if (wr_addr == ADDR_W'(i)) begin
                        ld_en[i]   = 1'b1;
                        ld_data[i] = wr_data;
                    end
                end
                OP_XCHG: begin
                    // A self-exchange is a no-op, so only distinct indices load
                    if (rd_a_addr != rd_b_addr) begin
                        if (rd_a_addr == ADDR_W'(i)) begin
                            ld_en[i]   = 1'b1;
                            ld_data[i] = q[rd_b_addr];
                        end else if (rd_b_addr == ADDR_W'(i)) begin
                            ld_en[i]   = 1'b1;
                            ld_data[i] = q[rd_a_addr];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage array, one cell per register
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_file_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk     (clk),
            .clr     (clr),
            .ld_en   (ld_en[g]),
            .ld_data (ld_data[g]),
            .q       (q[g])
        );
    end

`ifdef REG_FILE_BYPASS_EN
    // Read muxes with same-edge write forwarding; exchanges never forward
    always_comb begin
        rd_a_next = q[rd_a_addr];
        rd_b_next = q[rd_b_addr];
        if (op == OP_WRITE && rd_a_addr == wr_addr) begin
            rd_a_next = wr_data;
        end
        if (op == OP_WRITE && rd_b_addr == wr_addr) begin
            rd_b_next = wr_data;
        end
    end
`else
    // Read muxes return the pre-edge contents of the bank
    always_comb begin
        rd_a_next = q[rd_a_addr];
        rd_b_next = q[rd_b_addr];
    end
`endif

    // Output registers: read data holds when no read is requested
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            rd_a_data <= '0;
            rd_b_data <= '0;
            rd_valid  <= 1'b0;
            wr_ack    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            wr_ack   <= (op == OP_WRITE);
            if (rd_en) begin
                rd_a_data <= rd_a_next;
                rd_b_data <= rd_b_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w: table of vectors with hand-derived
// expectations pushed to a scoreboard queue, plus hand-written reset and
// wide-configuration sequences.
module tb_reg_file_2r1w;

    logic       clk = 1'b0;
    logic       clr;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       rd_en;
    logic [2:0] rd_a_addr;
    logic [2:0] rd_b_addr;
    logic [7:0] rd_a_data;
    logic [7:0] rd_b_data;
    logic       rd_valid;
    logic       xchg_en;

    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [15:0] w_wr_data;
    logic        w_wr_ack;
    logic        w_rd_en;
    logic [4:0]  w_rd_a_addr;
    logic [4:0]  w_rd_b_addr;
    logic [15:0] w_rd_a_data;
    logic [15:0] w_rd_b_data;
    logic        w_rd_valid;
    logic        w_xchg_en;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [7:0] R6_SAME_EDGE = 8'h02;
`else
    localparam logic [7:0] R6_SAME_EDGE = 8'h01;
`endif

    always #5 clk = ~clk;

    reg_file_2r1w dut (
        .clk       (clk),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_en     (rd_en),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .rd_a_data (rd_a_data),
        .rd_b_data (rd_b_data),
        .rd_valid  (rd_valid),
        .xchg_en   (xchg_en)
    );

    reg_file_2r1w #(
        .DATA_W (16),
        .DEPTH  (32)
    ) dut_wide (
        .clk       (clk),
        .clr       (clr),
        .wr_en     (w_wr_en),
        .wr_addr   (w_wr_addr),
        .wr_data   (w_wr_data),
        .wr_ack    (w_wr_ack),
        .rd_en     (w_rd_en),
        .rd_a_addr (w_rd_a_addr),
        .rd_b_addr (w_rd_b_addr),
        .rd_a_data (w_rd_a_data),
        .rd_b_data (w_rd_b_data),
        .rd_valid  (w_rd_valid),
        .xchg_en   (w_xchg_en)
    );

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       rd_en;
        logic [2:0] a_addr;
        logic [2:0] b_addr;
        logic       xchg;
        logic       exp_valid;
        logic       exp_ack;
        bit         chk_data;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    typedef struct {
        string      name;
        logic       exp_valid;
        logic       exp_ack;
        bit         chk_data;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                input logic re, input logic [2:0] aa, input logic [2:0] ba,
                                input logic xc, input logic ev, input logic ek,
                                input bit cd, input logic [7:0] ea, input logic [7:0] eb);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.rd_en = re;
        v.a_addr = aa; v.b_addr = ba; v.xchg = xc; v.exp_valid = ev;
        v.exp_ack = ek; v.chk_data = cd; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        check_val({e.name, ".rd_valid"}, 16'(rd_valid), 16'(e.exp_valid));
        check_val({e.name, ".wr_ack"}, 16'(wr_ack), 16'(e.exp_ack));
        if (e.chk_data) begin
            check_val({e.name, ".rd_a_data"}, 16'(rd_a_data), 16'(e.exp_a));
            check_val({e.name, ".rd_b_data"}, 16'(rd_b_data), 16'(e.exp_b));
        end
    endtask

    // Drive one vector, let the falling edge act, then compare at the rising edge
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        wr_en     = v.wr_en;
        wr_addr   = v.wr_addr;
        wr_data   = v.wr_data;
        rd_en     = v.rd_en;
        rd_a_addr = v.a_addr;
        rd_b_addr = v.b_addr;
        xchg_en   = v.xchg;
        e.name = name; e.exp_valid = v.exp_valid; e.exp_ack = v.exp_ack;
        e.chk_data = v.chk_data; e.exp_a = v.exp_a; e.exp_b = v.exp_b;
        sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic wide_step(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                             input logic re, input logic [4:0] aa, input logic [4:0] ba);
        w_wr_en = we; w_wr_addr = wa; w_wr_data = wd;
        w_rd_en = re; w_rd_a_addr = aa; w_rd_b_addr = ba;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0;
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0;
        rd_a_addr = 0; rd_b_addr = 0; xchg_en = 0;
        w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_rd_en = 0;
        w_rd_a_addr = 0; w_rd_b_addr = 0; w_xchg_en = 0;

        // Expectations are derived by hand from the intended behaviour
        vecs[0]  = mk(1, 3'd5, 8'h3C, 0, 3'd0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[1]  = mk(0, 3'd0, 8'h00, 1, 3'd5, 3'd0, 0, 1, 0, 1, 8'h3C, 8'h00);
        vecs[2]  = mk(1, 3'd1, 8'h11, 0, 3'd0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[3]  = mk(1, 3'd2, 8'h22, 0, 3'd0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[4]  = mk(0, 3'd0, 8'h00, 1, 3'd1, 3'd2, 1, 1, 0, 1, 8'h11, 8'h22);
        vecs[5]  = mk(0, 3'd0, 8'h00, 1, 3'd1, 3'd2, 0, 1, 0, 1, 8'h22, 8'h11);
        vecs[6]  = mk(1, 3'd4, 8'h44, 0, 3'd0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[7]  = mk(0, 3'd0, 8'h00, 0, 3'd4, 3'd4, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[8]  = mk(0, 3'd0, 8'h00, 1, 3'd4, 3'd4, 0, 1, 0, 1, 8'h44, 8'h44);
        vecs[9]  = mk(1, 3'd7, 8'h70, 0, 3'd0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[10] = mk(1, 3'd7, 8'hFF, 0, 3'd1, 3'd2, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[11] = mk(0, 3'd0, 8'h00, 1, 3'd7, 3'd1, 0, 1, 0, 1, 8'h70, 8'h11);
        vecs[12] = mk(0, 3'd0, 8'h00, 0, 3'd2, 3'd3, 0, 0, 0, 1, 8'h70, 8'h11);
        vecs[13] = mk(1, 3'd6, 8'h01, 0, 3'd0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[14] = mk(1, 3'd6, 8'h02, 1, 3'd6, 3'd5, 0, 1, 1, 1, R6_SAME_EDGE, 8'h3C);
        vecs[15] = mk(0, 3'd0, 8'h00, 1, 3'd6, 3'd6, 0, 1, 0, 1, 8'h02, 8'h02);

        // Reset state while clr is held low
        #12;
        check_val("reset.rd_a_data", 16'(rd_a_data), 16'h0);
        check_val("reset.rd_valid", 16'(rd_valid), 16'h0);
        check_val("reset.wr_ack", 16'(wr_ack), 16'h0);
        @(posedge clk);
        #1;
        clr = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-stream reset: outputs busy, then clr drops asynchronously
        applyStimulus(mk(1, 3'd3, 8'hA5, 1, 3'd5, 3'd0, 0, 1, 1, 1, 8'h3C, 8'h00), "pre_reset");
        #2;
        clr = 1'b0;
        #1;
        check_val("async_clr.rd_a_data", 16'(rd_a_data), 16'h0);
        check_val("async_clr.rd_valid", 16'(rd_valid), 16'h0);
        check_val("async_clr.wr_ack", 16'(wr_ack), 16'h0);
        applyStimulus(mk(0, 3'd0, 8'h00, 1, 3'd3, 3'd5, 0, 0, 0, 1, 8'h00, 8'h00), "in_reset");
        clr = 1'b1;
        applyStimulus(mk(0, 3'd0, 8'h00, 1, 3'd3, 3'd5, 0, 1, 0, 1, 8'h00, 8'h00), "post_reset");

        // Wide configuration: top and bottom registers
        wide_step(1, 5'd31, 16'hBEEF, 0, 5'd0, 5'd0);
        check_val("wide.wr_ack", 16'(w_wr_ack), 16'h1);
        wide_step(1, 5'd0, 16'h1234, 0, 5'd0, 5'd0);
        wide_step(0, 5'd0, 16'h0000, 1, 5'd31, 5'd0);
        check_val("wide.rd_a_data", w_rd_a_data, 16'hBEEF);
        check_val("wide.rd_b_data", w_rd_b_data, 16'h1234);
        check_val("wide.rd_valid", 16'(w_rd_valid), 16'h1);
        check_val("wide.wr_ack_idle", 16'(w_wr_ack), 16'h0);

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file for the microprocessor datapath: DEPTH registers of DATA_W bits, two registered read ports and one write port. It adds an atomic exchange operation and a write-acknowledge. It sits between the instruction decoder (operand_a/operand_b select the read addresses) and the ALU/bus. It replaces the fixed 8×8 tri-state register bank with a multiplexed, bus-free design.

## Interface
- DATA_W, 8, register width in bits
- DEPTH, 8, number of registers; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- clk  input  1  clock; all state updates on the falling edge
- clr  input  1  reset; asynchronous, active-low
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write register index
- wr_data  input  DATA_W  write data
- wr_ack  output  1  write committed this cycle
- rd_en  input  1  read request, both ports
- rd_a_addr  input  ADDR_W  port A index
- rd_b_addr  input  ADDR_W  port B index
- rd_a_data  output  DATA_W  port A data
- rd_b_data  output  DATA_W  port B data
- rd_valid  output  1  rd_a_data/rd_b_data valid
- xchg_en  input  1  swap contents of registers rd_a_addr and rd_b_addr

## Operation
- Reset (clr low, any time): all registers are cleared to 0, along with rd_a_data, rd_b_data, rd_valid and wr_ack. This holds even mid-operation; the first falling edge after clr rises behaves as a normal cycle.
- Write: when wr_en=1 and xchg_en=0, register wr_addr loads wr_data at the falling edge, and wr_ack=1 for that cycle.
- Exchange: when xchg_en=1, reg[rd_a_addr] and reg[rd_b_addr] swap atomically at one edge.
  - If rd_a_addr==rd_b_addr, no register changes.
  - Exchange has priority over write: a concurrent wr_en is dropped and wr_ack=0. The requester must retry.
- Read: on an edge with rd_en=1, the outputs are updated as follows:
  - rd_a_data ← reg[rd_a_addr] and rd_b_data ← reg[rd_b_addr], sampled pre-edge, before the same-edge write or exchange.
  - rd_valid=1.
- With rd_en=0: rd_valid=0 and the data outputs hold their last values.
- Read during exchange returns the pre-swap values.
- Indices are always in range because DEPTH is a power of two; no error path exists.

## Timing
- Write: committed at edge N; readable by a read sampled at edge N+1 (see Configuration for the bypass).
- Read latency is 1 cycle: a request at edge N gives data and rd_valid during cycle N to N+1.
- Back-to-back reads are allowed every cycle.
- wr_ack is registered and asserted for the cycle following the committing edge.
- No combinational path from any input to any output.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding.
  - When a read port address equals wr_addr and the write commits on the same edge (wr_en=1, xchg_en=0), that port returns wr_data instead of the stale value.
  - Applies to each port independently.
  - Not applied during an exchange.
- Undefined: reads always return the pre-edge register contents, as described in Operation.

## Structure
- Package reg_file_pkg holds:
  - default DATA_W and DEPTH constants;
  - an operation enum (OP_IDLE, OP_WRITE, OP_XCHG) used by the priority logic.
- Sub-module reg_file_cell: one DATA_W register with async active-low clear, load enable and load data, instantiated DEPTH times via a generate loop.
- Top-level holds the read multiplexers, the exchange/write select logic and the output registers.

## Test plan
- Reset: drive clr low mid-stream after writing 8'hA5 to r3; then read r3 → rd_a_data=0, rd_valid=0 during reset, and 0 after release.
- Write/read: write 8'h3C to r5; next cycle rd_en with A=5, B=0 → one cycle later rd_a_data=8'h3C, rd_b_data=0, rd_valid=1, and wr_ack was 1 for one cycle.
- Exchange: r1=8'h11, r2=8'h22; xchg_en with A=1, B=2 → a subsequent read gives r1=8'h22, r2=8'h11. A self-exchange with A=B=4 leaves r4 unchanged.
- Priority: xchg_en and wr_en (r7←8'hFF) on the same edge → wr_ack=0 and r7 keeps its old value.
- Same-edge read/write on r6 (old 8'h01, new 8'h02):
  - without REG_FILE_BYPASS_EN → rd_a_data=8'h01;
  - with it → rd_a_data=8'h02.
- Parametrisation: DATA_W=16, DEPTH=32; write 16'hBEEF to r31 and read it back → rd_a_data=16'hBEEF.
